// File: rtl/seven_seg_scan_pkg.sv
// Shared constants for the multiplexed seven-segment scanner.
// Digit enables are active-low; DIGIT_ON is the level that lights a digit.
package seven_seg_scan_pkg;

  localparam int NUM_DIGITS_DEF  = 8;
  localparam int REFRESH_DIV_DEF = 50000;
  localparam int DATA_W          = 32;
  localparam int NIB_W           = 4;

  localparam logic DIGIT_ON  = 1'b0;
  localparam logic DIGIT_OFF = ~DIGIT_ON;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int div_width(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

endpackage

// File: rtl/seven_seg_scan_timer.sv
// Refresh divider plus digit counter: tick on each divider wrap, idx is the
// digit being scanned, frame_end marks the wrap that closes the last digit.
module scan_timer
  import seven_seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS  = NUM_DIGITS_DEF,
  parameter int REFRESH_DIV = REFRESH_DIV_DEF
) (
  input  logic                                clk,
  input  logic                                clr,
  output logic                                tick,
  output logic [idx_width(NUM_DIGITS)-1:0]    idx,
  output logic                                frame_end
);

  localparam int IDX_W = idx_width(NUM_DIGITS);
  localparam int DIV_W = div_width(REFRESH_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             wrap;
  logic             last_digit;

  always_comb begin
    wrap       = (div_q == DIV_LAST);
    last_digit = (idx_q == IDX_LAST);

    div_d = div_q + DIV_W'(1);
    idx_d = idx_q;
    if (wrap) begin
      div_d = '0;
      idx_d = last_digit ? '0 : idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      div_q <= '0;
      idx_q <= '0;
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
    end
  end

  assign tick      = wrap;
  assign idx       = idx_q;
  assign frame_end = wrap & last_digit;

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed hex display driver: double-buffered value, frame-aligned
// display updates, optional leading-zero blanking, registered digit outputs.
module seven_seg_scan
  import seven_seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS  = NUM_DIGITS_DEF,
  parameter int REFRESH_DIV = REFRESH_DIV_DEF
) (
  input  logic                              clk,
  input  logic                              clr,
  input  logic                              out_en,
  input  logic [DATA_W-1:0]                 out_data,
  input  logic                              blank_lz,
  output logic [NIB_W-1:0]                  nibble,
  output logic [NUM_DIGITS-1:0]             digit_sel,
  output logic [idx_width(NUM_DIGITS)-1:0]  digit_idx,
  output logic                              frame_done
);

  localparam int IDX_W  = idx_width(NUM_DIGITS);
  localparam int DISP_W = NIB_W * NUM_DIGITS;

  logic             tick;
  logic [IDX_W-1:0] idx;
  logic             frame_end;
  logic             frame_boundary;

  scan_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .REFRESH_DIV (REFRESH_DIV)
  ) u_timer (
    .clk       (clk),
    .clr       (clr),
    .tick      (tick),
    .idx       (idx),
    .frame_end (frame_end)
  );

  // A frame only ends on a divider wrap, never mid-slot.
  assign frame_boundary = frame_end & tick;

  logic [DISP_W-1:0] shadow_q, shadow_d;
  logic [DISP_W-1:0] display_q, display_d;

  always_comb begin
    shadow_d  = out_en ? out_data[DISP_W-1:0] : shadow_q;
    // shadow_d already carries a coincident write, so the newest value wins.
    display_d = frame_boundary ? shadow_d : display_q;
  end

  logic [NIB_W-1:0]      digit_nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] upper_zero;
  logic [NUM_DIGITS-1:0] sel_hit;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign digit_nib[gi]  = display_q[NIB_W*gi +: NIB_W];
    assign upper_zero[gi] = ~|display_q[DISP_W-1 : NIB_W*gi];
    assign sel_hit[gi]    = (idx == IDX_W'(gi));
  end

  logic                  blanked;
  logic [NIB_W-1:0]      nibble_q, nibble_d;
  logic [NUM_DIGITS-1:0] digit_sel_q, digit_sel_d;
  logic [IDX_W-1:0]      digit_idx_q, digit_idx_d;
  logic                  frame_done_q, frame_done_d;

  always_comb begin
    blanked      = blank_lz && (idx != '0) && upper_zero[idx];
    nibble_d     = digit_nib[idx];
    digit_idx_d  = idx;
    frame_done_d = frame_boundary;
    digit_sel_d  = {NUM_DIGITS{DIGIT_OFF}};
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (sel_hit[k] && !blanked) begin
        digit_sel_d[k] = DIGIT_ON;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      shadow_q     <= '0;
      display_q    <= '0;
      nibble_q     <= '0;
      digit_sel_q  <= {NUM_DIGITS{DIGIT_OFF}};
      digit_idx_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      display_q    <= display_d;
      nibble_q     <= nibble_d;
      digit_sel_q  <= digit_sel_d;
      digit_idx_q  <= digit_idx_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign nibble     = nibble_q;
  assign digit_sel  = digit_sel_q;
  assign digit_idx  = digit_idx_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan with 8 digits and a 4-cycle refresh slot.
module tb_seven_seg_scan;

  logic        clk = 1'b0;
  logic        clr;
  logic        out_en;
  logic [31:0] out_data;
  logic        blank_lz;
  logic [3:0]  nibble;
  logic [7:0]  digit_sel;
  logic [2:0]  digit_idx;
  logic        frame_done;

  int n_cmp  = 0;
  int n_err  = 0;
  int edge_n = 0;

  seven_seg_scan #(
    .NUM_DIGITS  (8),
    .REFRESH_DIV (4)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .out_en     (out_en),
    .out_data   (out_data),
    .blank_lz   (blank_lz),
    .nibble     (nibble),
    .digit_sel  (digit_sel),
    .digit_idx  (digit_idx),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s edge=%0d: observed %0h expected %0h", tag, edge_n, obs, exp);
      $error("%s edge=%0d observed %0h expected %0h", tag, edge_n, obs, exp);
    end
  endtask

  // Outputs after edge n show digit (n-1)/4 of the frame; frame_done follows every 32nd edge.
  task automatic run_to(input int last, input logic [31:0] disp, input logic blz);
    int          k;
    logic [31:0] upper;
    logic [7:0]  exp_sel;
    logic [3:0]  exp_nib;
    while (edge_n < last) begin
      @(posedge clk);
      #1;
      edge_n++;
      k       = ((edge_n - 1) / 4) % 8;
      upper   = disp >> (4 * k);
      exp_sel = ~(8'h01 << k);
      if (blz && k > 0 && upper == 32'h0) exp_sel = 8'hFF;
      exp_nib = disp[4*k +: 4];
      chk("digit_sel", {24'h0, digit_sel}, {24'h0, exp_sel});
      chk("nibble", {28'h0, nibble}, {28'h0, exp_nib});
      chk("digit_idx", {29'h0, digit_idx}, k);
      chk("frame_done", {31'h0, frame_done}, {31'h0, (edge_n % 32) == 0});
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_sel"}, {24'h0, digit_sel}, 32'hFF);
    chk({tag, "_nib"}, {28'h0, nibble}, 32'h0);
    chk({tag, "_idx"}, {29'h0, digit_idx}, 32'h0);
    chk({tag, "_fd"}, {31'h0, frame_done}, 32'h0);
  endtask

  initial begin
    clr      = 1'b1;
    out_en   = 1'b0;
    out_data = 32'h0;
    blank_lz = 1'b0;
    @(posedge clk);
    #1;
    chk_reset("rst_hold");
    @(negedge clk);
    clr    = 1'b0;
    edge_n = 0;

    // Idle frame after reset, then a mid-frame write that must wait a frame.
    run_to(32, 32'h0, 1'b0);
    run_to(39, 32'h0, 1'b0);
    out_en = 1'b1; out_data = 32'h1234ABCD;
    run_to(40, 32'h0, 1'b0);
    out_en = 1'b0; out_data = 32'h0;
    run_to(64, 32'h0, 1'b0);
    run_to(65, 32'h1234ABCD, 1'b0);
    chk("spot_d_nib", {28'h0, nibble}, 32'hD);
    chk("spot_d_sel", {24'h0, digit_sel}, 32'hFE);
    run_to(79, 32'h1234ABCD, 1'b0);

    // Leading-zero blanking with 0xA0, then with 0.
    blank_lz = 1'b1;
    out_en = 1'b1; out_data = 32'h000000A0;
    run_to(80, 32'h1234ABCD, 1'b1);
    out_en = 1'b0;
    run_to(96, 32'h1234ABCD, 1'b1);
    run_to(97, 32'h000000A0, 1'b1);
    chk("spot_a0_idx0_sel", {24'h0, digit_sel}, 32'hFE);
    run_to(101, 32'h000000A0, 1'b1);
    chk("spot_a0_idx1_nib", {28'h0, nibble}, 32'hA);
    chk("spot_a0_idx1_sel", {24'h0, digit_sel}, 32'hFD);
    run_to(105, 32'h000000A0, 1'b1);
    chk("spot_a0_idx2_sel", {24'h0, digit_sel}, 32'hFF);
    run_to(109, 32'h000000A0, 1'b1);
    out_en = 1'b1; out_data = 32'h0;
    run_to(110, 32'h000000A0, 1'b1);
    out_en = 1'b0;
    run_to(128, 32'h000000A0, 1'b1);
    run_to(129, 32'h0, 1'b1);
    chk("spot_zero_idx0_sel", {24'h0, digit_sel}, 32'hFE);
    run_to(133, 32'h0, 1'b1);
    chk("spot_zero_idx1_sel", {24'h0, digit_sel}, 32'hFF);

    // Shadowed 0x11111111 overtaken by a write on the boundary edge itself.
    run_to(139, 32'h0, 1'b1);
    out_en = 1'b1; out_data = 32'h11111111;
    run_to(140, 32'h0, 1'b1);
    out_en = 1'b0;
    run_to(159, 32'h0, 1'b1);
    out_en = 1'b1; out_data = 32'h55555555;
    run_to(160, 32'h0, 1'b1);
    out_en = 1'b0; out_data = 32'h0;
    blank_lz = 1'b0;
    run_to(161, 32'h55555555, 1'b0);
    chk("spot_5_nib", {28'h0, nibble}, 32'h5);
    run_to(211, 32'h55555555, 1'b0);

    // Pending write, then clear mid-slot at idx 5 / divider 2.
    out_en = 1'b1; out_data = 32'h99999999;
    run_to(212, 32'h55555555, 1'b0);
    out_en = 1'b0; out_data = 32'h0;
    run_to(214, 32'h55555555, 1'b0);
    chk("spot_pre_clr_idx", {29'h0, digit_idx}, 32'h5);
    #2;
    clr = 1'b1;
    #1;
    chk_reset("clr_async");
    @(posedge clk);
    #1;
    chk_reset("clr_held");
    @(negedge clk);
    clr    = 1'b0;
    edge_n = 0;
    run_to(40, 32'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
